// File: rtl/lsu_bus.sv
// ---------------------------------------------------------------------------
// lsu_bus -- load/store unit with a split request/response memory bus.
//
// Takes one instruction at a time from EXU (valid/ready), performs at most
// one memory access over the request/response bus, and presents the result
// to WBU (valid/ready) from a single output register. Non-memory
// instructions pass straight through to that register with 1-cycle latency.
//
// Parameters
//   XLEN      : data/address width, 32 or 64
//   PAYLOAD_W : width of the opaque sideband bundle carried to WBU
//   TIMEOUT   : max cycles spent waiting for a response (0 = wait forever)
//
// Optional build macro
//   LSU_ALIGN_CHECK_EN : when defined, accesses whose byte offset is not a
//                        multiple of their size fault with cause 001 and are
//                        never issued. When undefined they are issued as-is.
//
// Ports
//   clk, rst                        : clock, synchronous active-high reset
//   i_pre_valid / o_pre_ready       : EXU handshake
//   i_is_load, i_is_store, i_func3  : access type and size/sign
//   i_addr, i_wdata, i_payload      : address (or non-memory result), store
//                                     data, sideband bundle
//   o_post_valid / i_post_ready     : WBU handshake
//   o_rd, o_payload                 : writeback value, sideband bundle
//   o_err, o_err_cause              : fault flag and cause
//                                     (001 misaligned, 010 bus error,
//                                      011 timeout, 100 illegal func3)
//   o_mem_req_valid / i_mem_req_ready, o_mem_we, o_mem_addr,
//   o_mem_wdata, o_mem_wstrb        : memory request channel
//   i_mem_rsp_valid / o_mem_rsp_ready, i_mem_rdata, i_mem_rsp_err
//                                   : memory response channel
// ---------------------------------------------------------------------------
module lsu_bus #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 160,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  input  logic                 i_is_load,
  input  logic                 i_is_store,
  input  logic [2:0]           i_func3,
  input  logic [XLEN-1:0]      i_addr,
  input  logic [XLEN-1:0]      i_wdata,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic [XLEN-1:0]      o_rd,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic                 o_err,
  output logic [2:0]           o_err_cause,
  output logic                 o_mem_req_valid,
  input  logic                 i_mem_req_ready,
  output logic                 o_mem_we,
  output logic [XLEN-1:0]      o_mem_addr,
  output logic [XLEN-1:0]      o_mem_wdata,
  output logic [XLEN/8-1:0]    o_mem_wstrb,
  input  logic                 i_mem_rsp_valid,
  output logic                 o_mem_rsp_ready,
  input  logic [XLEN-1:0]      i_mem_rdata,
  input  logic                 i_mem_rsp_err
);

  localparam int STRB_W   = XLEN / 8;
  localparam int OFF_W    = $clog2(STRB_W);
  // Counter only needs to reach TIMEOUT-1.
  localparam int CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_OUT} state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'b000,
    CAUSE_MISALIGN = 3'b001,
    CAUSE_BUS      = 3'b010,
    CAUSE_TIMEOUT  = 3'b011,
    CAUSE_ILLEGAL  = 3'b100
  } cause_t;

  state_t                 state_q, state_d;
  logic                   timeout_hit;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             func3_q;
  logic [OFF_W-1:0]       off_q;
  logic [XLEN-1:0]        rd_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic                   err_q;
  cause_t                 cause_q;
  logic                   mem_we_q;
  logic [XLEN-1:0]        mem_addr_q;
  logic [XLEN-1:0]        mem_wdata_q;
  logic [STRB_W-1:0]      mem_wstrb_q;

  // ---------------------------------------------------------------------
  // Decode of the incoming instruction (only meaningful in IDLE).
  // ---------------------------------------------------------------------
  logic [OFF_W-1:0]  in_off;
  logic              is_mem;
  logic              func3_ok;
  logic              misaligned;
  logic              issue_ok;
  logic [STRB_W-1:0] size_strb;

  assign in_off = i_addr[OFF_W-1:0];
  assign is_mem = i_is_load | i_is_store;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    func3_ok = 1'b0;
    if (i_is_load && i_is_store) begin
      func3_ok = 1'b0;
    end else if (i_is_load) begin
      unique case (i_func3)
        3'b000, 3'b001, 3'b010,
        3'b100, 3'b101:         func3_ok = 1'b1;
        3'b011, 3'b110:         func3_ok = (XLEN == 64);
        default:                func3_ok = 1'b0;
      endcase
    end else if (i_is_store) begin
      unique case (i_func3)
        3'b000, 3'b001, 3'b010: func3_ok = 1'b1;
        3'b011:                 func3_ok = (XLEN == 64);
        default:                func3_ok = 1'b0;
      endcase
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  // Offset bits that must be zero for a naturally aligned access.
  logic [OFF_W-1:0] align_mask;
  always_comb begin
    align_mask = '0;
    unique case (i_func3[1:0])
      2'd0:    align_mask = '0;
      2'd1:    align_mask = OFF_W'(1);
      2'd2:    align_mask = OFF_W'(3);
      default: align_mask = OFF_W'(7);
    endcase
  end
  assign misaligned = |(in_off & align_mask);
`else
  assign misaligned = 1'b0;
`endif

  assign issue_ok = is_mem & func3_ok & ~misaligned;

  always_comb begin
    size_strb = '0;
    unique case (i_func3[1:0])
      2'd0:    size_strb = STRB_W'(8'h01);
      2'd1:    size_strb = STRB_W'(8'h03);
      2'd2:    size_strb = STRB_W'(8'h0F);
      default: size_strb = STRB_W'(8'hFF);
    endcase
  end

  // ---------------------------------------------------------------------
  // Load data extraction from the aligned response word.
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] rsp_shift;
  logic [XLEN-1:0] load_val;

  assign rsp_shift = i_mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = rsp_shift;
    unique case (func3_q)
      3'b000:  load_val = XLEN'($signed(rsp_shift[7:0]));
      3'b001:  load_val = XLEN'($signed(rsp_shift[15:0]));
      3'b010:  load_val = XLEN'($signed(rsp_shift[31:0]));
      3'b100:  load_val = XLEN'(rsp_shift[7:0]);
      3'b101:  load_val = XLEN'(rsp_shift[15:0]);
      3'b110:  load_val = XLEN'(rsp_shift[31:0]);
      default: load_val = rsp_shift;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE: if (i_pre_valid) state_d = issue_ok ? S_REQ : S_OUT;
      S_REQ:  if (i_mem_req_ready) state_d = S_RSP;
      S_RSP: begin
        // A response arriving in the last allowed cycle still wins.
        if (i_mem_rsp_valid) begin
          state_d = S_OUT;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TMO_LAST)) begin
          state_d     = S_OUT;
          timeout_hit = 1'b1;
        end
      end
      S_OUT:  if (i_post_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      func3_q     <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      payload_q   <= '0;
      err_q       <= 1'b0;
      cause_q     <= CAUSE_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_pre_valid) begin
          cnt_q       <= '0;
          func3_q     <= i_func3;
          off_q       <= in_off;
          payload_q   <= i_payload;
          mem_we_q    <= i_is_store;
          mem_addr_q  <= {i_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
          mem_wdata_q <= i_wdata << {in_off, 3'b000};
          // Strobe bits shifted past the word are dropped by the width.
          mem_wstrb_q <= size_strb << in_off;
          if (!is_mem) begin
            rd_q    <= i_addr;
            err_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
          end else if (!func3_ok) begin
            rd_q    <= '0;
            err_q   <= 1'b1;
            cause_q <= CAUSE_ILLEGAL;
          end else if (misaligned) begin
            rd_q    <= '0;
            err_q   <= 1'b1;
            cause_q <= CAUSE_MISALIGN;
          end else begin
            rd_q    <= '0;
            err_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
          end
        end
        S_RSP: begin
          if (i_mem_rsp_valid) begin
            if (i_mem_rsp_err) begin
              rd_q    <= '0;
              err_q   <= 1'b1;
              cause_q <= CAUSE_BUS;
            end else begin
              // Stores only get a write ack; nothing to write back.
              rd_q    <= mem_we_q ? '0 : load_val;
              err_q   <= 1'b0;
              cause_q <= CAUSE_NONE;
            end
          end else if (timeout_hit) begin
            rd_q    <= '0;
            err_q   <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pre_ready     = (state_q == S_IDLE);
  assign o_post_valid    = (state_q == S_OUT);
  assign o_mem_req_valid = (state_q == S_REQ);
  assign o_mem_rsp_ready = (state_q == S_RSP);
  assign o_rd            = rd_q;
  assign o_payload       = payload_q;
  assign o_err           = err_q;
  assign o_err_cause     = cause_q;
  assign o_mem_we        = mem_we_q;
  assign o_mem_addr      = mem_addr_q;
  assign o_mem_wdata     = mem_wdata_q;
  assign o_mem_wstrb     = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_bus.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus -- self-checking bench for lsu_bus (XLEN=32, TIMEOUT=4).
// A directed vector table covers the documented cases; a randomized phase
// compares against a behavioural model built from byte-level arithmetic.
// ---------------------------------------------------------------------------
module tb_lsu_bus;

  localparam int XLEN      = 32;
  localparam int PAYLOAD_W = 160;
  localparam int TMO       = 4;

  typedef logic [159:0] w_t;

  typedef struct {
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          rerr;
    int          req_wait;
    int          rsp_wait;
    int          post_wait;
    bit          x_req;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic [3:0]  x_strb;
    logic [31:0] x_rd;
    bit          x_err;
    logic [2:0]  x_cause;
  } vec_t;

  logic                 clk;
  logic                 rst;
  logic                 i_pre_valid;
  logic                 o_pre_ready;
  logic                 o_post_valid;
  logic                 i_post_ready;
  logic                 i_is_load;
  logic                 i_is_store;
  logic [2:0]           i_func3;
  logic [XLEN-1:0]      i_addr;
  logic [XLEN-1:0]      i_wdata;
  logic [PAYLOAD_W-1:0] i_payload;
  logic [XLEN-1:0]      o_rd;
  logic [PAYLOAD_W-1:0] o_payload;
  logic                 o_err;
  logic [2:0]           o_err_cause;
  logic                 o_mem_req_valid;
  logic                 i_mem_req_ready;
  logic                 o_mem_we;
  logic [XLEN-1:0]      o_mem_addr;
  logic [XLEN-1:0]      o_mem_wdata;
  logic [XLEN/8-1:0]    o_mem_wstrb;
  logic                 i_mem_rsp_valid;
  logic                 o_mem_rsp_ready;
  logic [XLEN-1:0]      i_mem_rdata;
  logic                 i_mem_rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  lsu_bus #(.XLEN(XLEN), .PAYLOAD_W(PAYLOAD_W), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_pre_valid     (i_pre_valid),
    .o_pre_ready     (o_pre_ready),
    .o_post_valid    (o_post_valid),
    .i_post_ready    (i_post_ready),
    .i_is_load       (i_is_load),
    .i_is_store      (i_is_store),
    .i_func3         (i_func3),
    .i_addr          (i_addr),
    .i_wdata         (i_wdata),
    .i_payload       (i_payload),
    .o_rd            (o_rd),
    .o_payload       (o_payload),
    .o_err           (o_err),
    .o_err_cause     (o_err_cause),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_we        (o_mem_we),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wdata     (o_mem_wdata),
    .o_mem_wstrb     (o_mem_wstrb),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .o_mem_rsp_ready (o_mem_rsp_ready),
    .i_mem_rdata     (i_mem_rdata),
    .i_mem_rsp_err   (i_mem_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input w_t act, input w_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic w_t rand_payload();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behavioural reference: expected bus request and result from the
  // instruction fields, using byte counts and 64-bit arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          n;
    int          off;
    bit          legal;
    longint unsigned lv;
    longint unsigned mask;
    r     = v;
    n     = 1 << v.f3[1:0];
    off   = int'(v.addr % 4);
    legal = 1'b0;
    if (v.ld && !v.st) legal = (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (v.st && !v.ld) legal = (v.f3 inside {3'd0, 3'd1, 3'd2});
    r.x_addr  = v.addr - 32'(off);
    r.x_wdata = 32'(64'(v.wdata) << (8 * off));
    r.x_strb  = 4'(((1 << n) - 1) << off);
    r.x_req   = 1'b0;
    r.x_rd    = '0;
    r.x_err   = 1'b0;
    r.x_cause = 3'd0;
    if (!v.ld && !v.st) begin
      r.x_rd = v.addr;
    end else if (!legal) begin
      r.x_err = 1'b1; r.x_cause = 3'd4;
`ifdef LSU_ALIGN_CHECK_EN
    end else if (off % n != 0) begin
      r.x_err = 1'b1; r.x_cause = 3'd1;
`endif
    end else begin
      r.x_req = 1'b1;
      if (v.rsp_wait >= TMO) begin
        r.x_err = 1'b1; r.x_cause = 3'd3;
      end else if (v.rerr) begin
        r.x_err = 1'b1; r.x_cause = 3'd2;
      end else if (v.ld) begin
        lv   = 64'(v.rdata) >> (8 * off);
        mask = (64'd1 << (8 * n)) - 1;
        lv   = lv & mask;
        if (!v.f3[2] && lv[8 * n - 1]) lv = lv | ~mask;
        r.x_rd = 32'(lv);
      end
    end
    return r;
  endfunction

  // Runs one instruction end-to-end with the given bus/WBU stall counts,
  // checking every cycle against the expectations carried in v.
  task automatic run_txn(input string tag, input vec_t v);
    w_t pl;
    int n_rsp;
    bit tmo;
    pl = rand_payload();
    check({tag, ".idle_ready"}, w_t'(o_pre_ready), w_t'(1'b1));
    i_pre_valid = 1'b1;
    i_is_load   = v.ld;
    i_is_store  = v.st;
    i_func3     = v.f3;
    i_addr      = v.addr;
    i_wdata     = v.wdata;
    i_payload   = pl[PAYLOAD_W-1:0];
    step();
    // Scramble inputs: the DUT must work from what it latched.
    i_pre_valid = 1'b0;
    i_is_load   = 1'($urandom);
    i_is_store  = 1'($urandom);
    i_func3     = 3'($urandom);
    i_addr      = $urandom;
    i_wdata     = $urandom;
    i_payload   = rand_payload();
    if (v.x_req) begin
      for (int i = 0; i <= v.req_wait; i++) begin
        check({tag, ".req_valid"}, w_t'(o_mem_req_valid), w_t'(1'b1));
        check({tag, ".req_we"},    w_t'(o_mem_we),        w_t'(v.st));
        check({tag, ".req_addr"},  w_t'(o_mem_addr),      w_t'(v.x_addr));
        check({tag, ".req_wdata"}, w_t'(o_mem_wdata),     w_t'(v.x_wdata));
        check({tag, ".req_wstrb"}, w_t'(o_mem_wstrb),     w_t'(v.x_strb));
        check({tag, ".req_postv"}, w_t'(o_post_valid),    w_t'(1'b0));
        i_mem_req_ready = (i == v.req_wait);
        step();
      end
      i_mem_req_ready = 1'b0;
      tmo   = (v.rsp_wait >= TMO);
      n_rsp = tmo ? TMO : v.rsp_wait;
      for (int i = 0; i < n_rsp; i++) begin
        check({tag, ".rsp_ready"}, w_t'(o_mem_rsp_ready), w_t'(1'b1));
        check({tag, ".rsp_reqv"},  w_t'(o_mem_req_valid), w_t'(1'b0));
        i_mem_rdata = $urandom;
        step();
      end
      if (!tmo) begin
        check({tag, ".rsp_ready"}, w_t'(o_mem_rsp_ready), w_t'(1'b1));
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata     = v.rdata;
        i_mem_rsp_err   = v.rerr;
        step();
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_err   = 1'b0;
      end else begin
        // Late response after the timeout must be refused.
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_err   = 1'b1;
        i_mem_rdata     = $urandom;
        check({tag, ".late_rsp_ready"}, w_t'(o_mem_rsp_ready), w_t'(1'b0));
      end
    end
    for (int i = 0; i <= v.post_wait; i++) begin
      check({tag, ".out_valid"},   w_t'(o_post_valid),    w_t'(1'b1));
      check({tag, ".out_rd"},      w_t'(o_rd),            w_t'(v.x_rd));
      check({tag, ".out_err"},     w_t'(o_err),           w_t'(v.x_err));
      check({tag, ".out_cause"},   w_t'(o_err_cause),     w_t'(v.x_cause));
      check({tag, ".out_payload"}, w_t'(o_payload),       w_t'(pl[PAYLOAD_W-1:0]));
      check({tag, ".out_reqv"},    w_t'(o_mem_req_valid), w_t'(1'b0));
      check({tag, ".out_preready"},w_t'(o_pre_ready),     w_t'(1'b0));
      i_post_ready = (i == v.post_wait);
      step();
    end
    i_post_ready    = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_err   = 1'b0;
    check({tag, ".done_postv"}, w_t'(o_post_valid), w_t'(1'b0));
  endtask

  vec_t tbl[16];
  vec_t rv;

  initial begin
    rst             = 1'b1;
    i_pre_valid     = 1'b0;
    i_post_ready    = 1'b0;
    i_is_load       = 1'b0;
    i_is_store      = 1'b0;
    i_func3         = '0;
    i_addr          = '0;
    i_wdata         = '0;
    i_payload       = '0;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rdata     = '0;
    i_mem_rsp_err   = 1'b0;

    //            ld    st    f3    addr          wdata         rdata         rerr rqw rsw pw   req   x_addr        x_wdata       strb   x_rd          err   cause
    tbl[0]  = '{1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0,        32'h0,        1'b0, 0, 0, 0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_1234, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0,        32'h80FF_0000, 1'b0, 0, 0, 0, 1'b1, 32'h0000_1000, 32'h0,       4'h8, 32'hFFFF_FF80, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, 1'b0, 3'd4, 32'h0000_1003, 32'h0,        32'h80FF_0000, 1'b0, 0, 0, 0, 1'b1, 32'h0000_1000, 32'h0,       4'h8, 32'h0000_0080, 1'b0, 3'd0};
    tbl[3]  = '{1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'h0000_ABCD, 32'h0,       1'b0, 3, 0, 0, 1'b1, 32'h0000_2000, 32'hABCD_0000, 4'hC, 32'h0,      1'b0, 3'd0};
    tbl[4]  = '{1'b1, 1'b0, 3'd2, 32'h0000_4000, 32'h0,        32'h1234_5678, 1'b1, 0, 1, 2, 1'b1, 32'h0000_4000, 32'h0,       4'hF, 32'h0,         1'b1, 3'd2};
    tbl[5]  = '{1'b1, 1'b0, 3'd1, 32'h0000_5002, 32'h0,        32'h8001_1234, 1'b0, 0, 0, 0, 1'b1, 32'h0000_5000, 32'h0,       4'hC, 32'hFFFF_8001, 1'b0, 3'd0};
    tbl[6]  = '{1'b1, 1'b0, 3'd5, 32'h0000_5002, 32'h0,        32'h8001_1234, 1'b0, 0, 0, 0, 1'b1, 32'h0000_5000, 32'h0,       4'hC, 32'h0000_8001, 1'b0, 3'd0};
    tbl[7]  = '{1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'h0,        32'h0,        1'b0, 0, 0, 0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,         1'b1, 3'd4};
    tbl[8]  = '{1'b1, 1'b1, 3'd0, 32'h0000_0100, 32'h0,        32'h0,        1'b0, 0, 0, 0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,         1'b1, 3'd4};
    tbl[9]  = '{1'b1, 1'b0, 3'd7, 32'h0000_0100, 32'h0,        32'h0,        1'b0, 0, 0, 0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,         1'b1, 3'd4};
    tbl[10] = '{1'b0, 1'b1, 3'd2, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0,       1'b0, 1, 2, 1, 1'b1, 32'h0000_6000, 32'hDEAD_BEEF, 4'hF, 32'h0,      1'b0, 3'd0};
    tbl[11] = '{1'b0, 1'b1, 3'd0, 32'h0000_7001, 32'h1234_565A, 32'h0,       1'b0, 0, 0, 0, 1'b1, 32'h0000_7000, 32'h3456_5A00, 4'h2, 32'h0,      1'b0, 3'd0};
    tbl[12] = '{1'b1, 1'b0, 3'd6, 32'h0000_0100, 32'h0,        32'h0,        1'b0, 0, 0, 0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,         1'b1, 3'd4};
    tbl[13] = '{1'b1, 1'b0, 3'd2, 32'h0000_8000, 32'h0,        32'h0,        1'b0, 0, 4, 0, 1'b1, 32'h0000_8000, 32'h0,        4'hF, 32'h0,         1'b1, 3'd3};
    tbl[14] = '{1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'h0,        32'h0,        1'b0, 0, 0, 0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,         1'b1, 3'd4};
`ifdef LSU_ALIGN_CHECK_EN
    tbl[15] = '{1'b1, 1'b0, 3'd2, 32'h0000_3001, 32'h0,        32'h1122_3344, 1'b0, 0, 0, 0, 1'b0, 32'h0,       32'h0,        4'h0, 32'h0,         1'b1, 3'd1};
`else
    tbl[15] = '{1'b1, 1'b0, 3'd2, 32'h0000_3001, 32'h0,        32'h1122_3344, 1'b0, 0, 0, 0, 1'b1, 32'h0000_3000, 32'h0,       4'hE, 32'h0011_2233, 1'b0, 3'd0};
`endif

    // Reset state
    step();
    step();
    check("rst.pre_ready",  w_t'(o_pre_ready),     w_t'(1'b1));
    check("rst.post_valid", w_t'(o_post_valid),    w_t'(1'b0));
    check("rst.req_valid",  w_t'(o_mem_req_valid), w_t'(1'b0));
    check("rst.rsp_ready",  w_t'(o_mem_rsp_ready), w_t'(1'b0));
    check("rst.rd",         w_t'(o_rd),            w_t'(0));
    check("rst.err",        w_t'(o_err),           w_t'(1'b0));
    check("rst.cause",      w_t'(o_err_cause),     w_t'(3'd0));
    check("rst.mem_addr",   w_t'(o_mem_addr),      w_t'(0));
    check("rst.wstrb",      w_t'(o_mem_wstrb),     w_t'(0));
    check("rst.payload",    w_t'(o_payload),       w_t'(0));
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i]);
    end

    // Reset while a request is outstanding, then a stray late response.
    i_pre_valid = 1'b1;
    i_is_load   = 1'b1;
    i_is_store  = 1'b0;
    i_func3     = 3'd2;
    i_addr      = 32'h0000_9000;
    step();
    i_pre_valid = 1'b0;
    check("rstreq.req_valid", w_t'(o_mem_req_valid), w_t'(1'b1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstreq.req_drop",   w_t'(o_mem_req_valid), w_t'(1'b0));
    check("rstreq.pre_ready",  w_t'(o_pre_ready),     w_t'(1'b1));
    check("rstreq.post_valid", w_t'(o_post_valid),    w_t'(1'b0));
    i_mem_rsp_valid = 1'b1;
    i_mem_rdata     = 32'hCAFE_F00D;
    check("rstreq.late_rsp_ready", w_t'(o_mem_rsp_ready), w_t'(1'b0));
    step();
    i_mem_rsp_valid = 1'b0;
    check("rstreq.still_idle", w_t'(o_pre_ready),  w_t'(1'b1));
    check("rstreq.no_out",     w_t'(o_post_valid), w_t'(1'b0));
    check("rstreq.rd_clear",   w_t'(o_rd),         w_t'(0));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      int k;
      k = int'($urandom_range(0, 7));
      rv.ld        = (k >= 2 && k <= 4) || k == 7;
      rv.st        = (k >= 5);
      rv.f3        = 3'($urandom);
      rv.addr      = $urandom;
      rv.wdata     = $urandom;
      rv.rdata     = $urandom;
      rv.rerr      = ($urandom_range(0, 5) == 0);
      rv.req_wait  = int'($urandom_range(0, 2));
      rv.rsp_wait  = ($urandom_range(0, 9) == 0) ? TMO + int'($urandom_range(0, 1))
                                                 : int'($urandom_range(0, 2));
      rv.post_wait = int'($urandom_range(0, 2));
      rv = model(rv);
      run_txn($sformatf("rnd%0d", i), rv);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
